// File: rtl/prbs31_pkg.sv
// Shared constants and types for the PRBS31 generator/checker tile.
// Holds the polynomial definition (x^31 + x^28 + 1), the uo_out select
// encodings, the checker lock states and the bit positions of every
// control/status field so the top and the checker agree on one layout.
package prbs31_pkg;

  localparam int PRBS_LEN = 31;
  localparam int TAP_A    = 30;
  localparam int TAP_B    = 27;
  localparam logic [PRBS_LEN-1:0] SEED = 31'h7FFF_FFFF;

  // uo_out source select (ui_in[7:6])
  typedef enum logic [1:0] {
    SEL_GEN    = 2'b00,
    SEL_ERR_LO = 2'b01,
    SEL_ERR_HI = 2'b10,
    SEL_STATUS = 2'b11
  } out_sel_t;

  // Checker lock state
  typedef enum logic {
    CHK_UNLOCKED = 1'b0,
    CHK_LOCKED   = 1'b1
  } chk_state_t;

  // ui_in control bits
  localparam int UI_GEN_EN   = 0;
  localparam int UI_CHK_EN   = 1;
  localparam int UI_INJECT   = 2;
  localparam int UI_RSVD     = 3;
  localparam int UI_LOOPBACK = 4;
  localparam int UI_CLR_ERR  = 5;
  localparam int UI_SEL_LO   = 6;
  localparam int UI_SEL_HI   = 7;

  // Status byte (uo_out when sel = SEL_STATUS)
  localparam int ST_GEN_EN  = 0;
  localparam int ST_CHK_EN  = 1;
  localparam int ST_ERR_SAT = 2;
  localparam int ST_LOCK    = 7;

  // uio bit roles
  localparam int UIO_RX        = 0;
  localparam int UIO_SER       = 1;
  localparam int UIO_LOCK      = 2;
  localparam int UIO_ERR_PULSE = 3;
  localparam int UIO_ERR_LO    = 4;
  localparam logic [7:0] UIO_OE_MASK = 8'b1111_1110;

  // Next PRBS bit predicted from a 31-bit history (bit 30 = oldest).
  function automatic logic prbs_fb(input logic [PRBS_LEN-1:0] s);
    return s[TAP_A] ^ s[TAP_B];
  endfunction

endpackage

// File: rtl/prbs31_checker.sv
// Self-synchronising PRBS31 checker.
// The received bits themselves form the reference history, so the checker
// locks onto any phase of the sequence without a seed.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   en           : step enable; when low all state holds except the fill
//                  counter, which restarts so the history is refilled
//   rx           : received serial bit
//   clr_err      : zero the error counter (wins over an increment)
//   state        : lock state (debug view; lock = CHK_LOCKED)
//   err_cnt      : saturating count of mismatches seen while locked
//   err_sat      : err_cnt is all-ones
//   err_pulse    : one-cycle pulse per counted mismatch
module prbs31_checker
  import prbs31_pkg::*;
#(
  parameter int ERR_W        = 16,
  parameter int LOCK_MATCHES = 32,
  parameter int UNLOCK_ERRS  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             rx,
  input  logic             clr_err,
  output chk_state_t       state,
  output logic [ERR_W-1:0] err_cnt,
  output logic             err_sat,
  output logic             err_pulse
);

  localparam int MW = $clog2(LOCK_MATCHES + 1);
  localparam int RW = $clog2(UNLOCK_ERRS + 1);
  localparam int FW = $clog2(PRBS_LEN + 1);
  localparam logic [MW-1:0] MATCH_FULL = MW'(LOCK_MATCHES);
  localparam logic [RW-1:0] RUN_LAST   = RW'(UNLOCK_ERRS - 1);
  localparam logic [FW-1:0] FILL_FULL  = FW'(PRBS_LEN);

  logic [PRBS_LEN-1:0] r,         r_next;
  logic [FW-1:0]       fill,      fill_next;
  logic [MW-1:0]       match_cnt, match_next;
  logic [RW-1:0]       err_run,   run_next;
  chk_state_t          state_next;
  logic [ERR_W-1:0]    err_next;
  logic                pulse_next;
  logic                pred;
  logic                mism;
  logic                cmp_valid;

  assign err_sat = &err_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r         <= '0;
      fill      <= '0;
      match_cnt <= '0;
      err_run   <= '0;
      state     <= CHK_UNLOCKED;
      err_cnt   <= '0;
      err_pulse <= 1'b0;
    end else begin
      r         <= r_next;
      fill      <= fill_next;
      match_cnt <= match_next;
      err_run   <= run_next;
      state     <= state_next;
      err_cnt   <= err_next;
      err_pulse <= pulse_next;
    end
  end

  always_comb begin
    r_next     = r;
    fill_next  = fill;
    match_next = match_cnt;
    run_next   = err_run;
    state_next = state;
    err_next   = err_cnt;
    pulse_next = 1'b0;
    pred       = prbs_fb(r);
    mism       = (pred != rx);
    // The prediction is only meaningful once r holds 31 received bits.
    cmp_valid  = (fill == FILL_FULL);

    if (!en) begin
      fill_next = '0;
    end else begin
      r_next = {r[PRBS_LEN-2:0], rx};
      if (!cmp_valid) begin
        fill_next = fill + FW'(1);
      end else begin
        case (state)
          CHK_UNLOCKED: begin
            if (mism) begin
              match_next = '0;
            end else begin
              if (match_cnt != MATCH_FULL) match_next = match_cnt + MW'(1);
              // An all-zero history predicts zeros forever; never lock on it.
              if (match_next == MATCH_FULL && r != '0) begin
                state_next = CHK_LOCKED;
                run_next   = '0;
              end
            end
          end
          CHK_LOCKED: begin
            if (mism) begin
              pulse_next = 1'b1;
              if (!err_sat) err_next = err_cnt + ERR_W'(1);
              if (err_run == RUN_LAST) begin
                state_next = CHK_UNLOCKED;
                match_next = '0;
                run_next   = '0;
              end else begin
                run_next = err_run + RW'(1);
              end
            end else begin
              run_next = '0;
            end
          end
          default: state_next = CHK_UNLOCKED;
        endcase
      end
    end

    if (clr_err) err_next = '0;
  end

endmodule

// File: rtl/tt_um_lampham_prbs31.sv
// TinyTapeout tile: PRBS31 (x^31 + x^28 + 1) generator plus
// self-synchronising checker with single-shot error injection.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   ena        : tile select (not used functionally)
//   ui_in      : [0] gen_en, [1] chk_en, [2] inject (rising edge),
//                [4] loopback, [5] clr_err, [7:6] uo_out select
//   uo_out     : 00 gen byte, 01 err_cnt[7:0], 10 err_cnt[15:8],
//                11 {lock, 0000, err_sat, chk_en_s, gen_en_s}
//   uio_in     : [0] external serial rx
//   uio_out    : [1] serial PRBS, [2] lock, [3] err_pulse, [7:4] err_cnt[3:0]
//   uio_oe     : constant 8'b1111_1110 (bit 0 is the rx input)
module tt_um_lampham_prbs31
  import prbs31_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int ERR_W        = 16,
  parameter int LOCK_MATCHES = 32,
  parameter int UNLOCK_ERRS  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // Synchronisers: {uio_in[0], ui_in} through SYNC_STAGES flops.
  logic [8:0] sync_q [SYNC_STAGES];
  logic [8:0] in_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {uio_in[UIO_RX], ui_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign in_s = sync_q[SYNC_STAGES-1];

  logic     gen_en_s, chk_en_s, inject_s, loopback_s, clr_err_s, rx_s;
  out_sel_t sel_s;

  assign gen_en_s   = in_s[UI_GEN_EN];
  assign chk_en_s   = in_s[UI_CHK_EN];
  assign inject_s   = in_s[UI_INJECT];
  assign loopback_s = in_s[UI_LOOPBACK];
  assign clr_err_s  = in_s[UI_CLR_ERR];
  assign sel_s      = out_sel_t'(in_s[UI_SEL_HI:UI_SEL_LO]);
  assign rx_s       = in_s[8];

  // Generator. The injected flip only touches the serial register, never
  // the LFSR, so the sequence itself stays intact.
  logic [PRBS_LEN-1:0] lfsr;
  logic                gen_bit;
  logic                ser_q;
  logic                inj_pend;
  logic                inj_prev;

  assign gen_bit = prbs_fb(lfsr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr     <= SEED;
      ser_q    <= 1'b0;
      inj_pend <= 1'b0;
      inj_prev <= 1'b0;
    end else begin
      inj_prev <= inject_s;
      if (gen_en_s) begin
        lfsr  <= {lfsr[PRBS_LEN-2:0], gen_bit};
        ser_q <= gen_bit ^ inj_pend;
      end
      // A fresh edge outranks the clear, so an edge arriving on an emitting
      // cycle still flips a later bit.
      if (inject_s && !inj_prev) inj_pend <= 1'b1;
      else if (gen_en_s)         inj_pend <= 1'b0;
    end
  end

  // Checker
  logic             rx;
  chk_state_t       chk_state;
  logic             lock;
  logic [ERR_W-1:0] err_cnt;
  logic             err_sat;
  logic             err_pulse;

  assign rx = loopback_s ? ser_q : rx_s;

  prbs31_checker #(
    .ERR_W        (ERR_W),
    .LOCK_MATCHES (LOCK_MATCHES),
    .UNLOCK_ERRS  (UNLOCK_ERRS)
  ) u_checker (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (chk_en_s),
    .rx        (rx),
    .clr_err   (clr_err_s),
    .state     (chk_state),
    .err_cnt   (err_cnt),
    .err_sat   (err_sat),
    .err_pulse (err_pulse)
  );

  assign lock = (chk_state == CHK_LOCKED);

  // Outputs
  logic [15:0] err16;
  logic [7:0]  gen_byte;
  logic [7:0]  status;

  assign err16    = 16'(err_cnt);
  // Reset is synchronous, so the LFSR shows the seed during reset; mask it.
  assign gen_byte = rst_n ? lfsr[7:0] : 8'h00;

  always_comb begin
    status             = '0;
    status[ST_GEN_EN]  = gen_en_s;
    status[ST_CHK_EN]  = chk_en_s;
    status[ST_ERR_SAT] = err_sat;
    status[ST_LOCK]    = lock;
  end

  always_comb begin
    uo_out = '0;
    case (sel_s)
      SEL_GEN:    uo_out = gen_byte;
      SEL_ERR_LO: uo_out = err16[7:0];
      SEL_ERR_HI: uo_out = err16[15:8];
      SEL_STATUS: uo_out = status;
      default:    uo_out = '0;
    endcase
  end

  always_comb begin
    uio_out                           = '0;
    uio_out[UIO_SER]                  = ser_q;
    uio_out[UIO_LOCK]                 = lock;
    uio_out[UIO_ERR_PULSE]            = err_pulse;
    uio_out[UIO_ERR_LO+3:UIO_ERR_LO]  = err16[3:0];
  end

  assign uio_oe = UIO_OE_MASK;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, in_s[UI_RSVD], uio_in[7:1]};

endmodule

// File: tb/tb_tt_um_lampham_prbs31.sv
// Bench for tt_um_lampham_prbs31: directed steps plus randomized phases,
// checked each cycle against a sequence-level reference model.
module tb_tt_um_lampham_prbs31;

  localparam int SYNC     = 2;
  localparam int LOCK_N   = 32;
  localparam int UNLOCK_N = 3;
  localparam int ERR_MAX  = 65535;

  // Clock / reset / DUT
  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tt_um_lampham_prbs31 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // Reference model
  // seq holds b_n for n = -30.. at index n+30; the seed history is all ones
  // and b_n = b_{n-31} ^ b_{n-28}.
  bit         seq[$];
  logic [8:0] m_pipe [SYNC];
  int         m_n;
  bit         m_ser, m_pend, m_inj_prev;
  bit         rx_hist[$];   // received bits, index 0 newest
  int         m_fill, m_match, m_run, m_err;
  bit         m_lock, m_pulse;

  function automatic bit prbs_bit(input int n);
    if (seq.size() == 0) for (int i = 0; i < 31; i++) seq.push_back(1'b1);
    if (n <= 0) return 1'b1;
    while (seq.size() < n + 31) seq.push_back(seq[seq.size()-31] ^ seq[seq.size()-28]);
    return seq[n+30];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) m_pipe[i] = '0;
    m_n = 0; m_ser = 0; m_pend = 0; m_inj_prev = 0;
    rx_hist.delete();
    for (int i = 0; i < 31; i++) rx_hist.push_back(1'b0);
    m_fill = 0; m_match = 0; m_run = 0; m_err = 0;
    m_lock = 0; m_pulse = 0;
  endtask

  // One clock edge, using the inputs driven before the edge.
  task automatic model_step();
    logic [8:0] s;
    bit rx, pred, nz;
    if (!rst_n) begin
      model_reset();
    end else begin
      s = m_pipe[SYNC-1];
      rx = s[4] ? m_ser : s[8];
      m_pulse = 0;
      if (s[1]) begin
        pred = rx_hist[30] ^ rx_hist[27];
        nz = 0;
        foreach (rx_hist[i]) nz = nz | rx_hist[i];
        rx_hist.push_front(rx);
        void'(rx_hist.pop_back());
        if (m_fill < 31) begin
          m_fill++;
        end else if (!m_lock) begin
          if (pred != rx) m_match = 0;
          else begin
            if (m_match < LOCK_N) m_match++;
            if (m_match == LOCK_N && nz) begin m_lock = 1; m_run = 0; end
          end
        end else begin
          if (pred != rx) begin
            m_pulse = 1;
            if (m_err < ERR_MAX) m_err++;
            m_run++;
            if (m_run == UNLOCK_N) begin m_lock = 0; m_match = 0; m_run = 0; end
          end else begin
            m_run = 0;
          end
        end
      end else begin
        m_fill = 0;
      end
      if (s[5]) m_err = 0;
      if (s[0]) begin
        m_n++;
        m_ser = prbs_bit(m_n) ^ m_pend;
        m_pend = 0;
      end
      if (s[2] && !m_inj_prev) m_pend = 1;
      m_inj_prev = s[2];
      for (int i = SYNC-1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = {uio_in[0], ui_in};
    end
  endtask

  function automatic logic [7:0] exp_uo();
    logic [7:0] r;
    logic [8:0] s;
    logic [15:0] e;
    s = m_pipe[SYNC-1];
    e = 16'(m_err);
    r = '0;
    if (rst_n) begin
      case (s[7:6])
        2'b00:   for (int i = 0; i < 8; i++) r[i] = prbs_bit(m_n - i);
        2'b01:   r = e[7:0];
        2'b10:   r = e[15:8];
        default: r = {m_lock, 4'b0000, (m_err == ERR_MAX), s[1], s[0]};
      endcase
    end
    return r;
  endfunction

  function automatic logic [7:0] exp_uio();
    logic [15:0] e;
    e = 16'(m_err);
    return {e[3:0], m_pulse, m_lock, m_ser, 1'b0};
  endfunction

  // Scoreboard
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("uo_out", uo_out, exp_uo());
    chk("uio_out", uio_out, exp_uio());
    chk("uio_oe", uio_oe, 8'hFE);
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ui_in = 8'h00;
    uio_in = 8'h00;
    tick_n(3);
  endtask

  task automatic wait_lock(input string tag, input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (uio_out[2] === 1'b1) begin lat = i; break; end
    end
    chk(tag, {7'b0, uio_out[2]}, 8'h01);
  endtask

  // Stimulus
  initial begin
    int lat;
    int pulses;
    bit seen;
    bit found;

    ena = 1'b1;
    rst_n = 1'b0;
    ui_in = 8'h00;
    uio_in = 8'h00;
    model_reset();

    // Reset state
    do_reset();
    chk("rst_uo", uo_out, 8'h00);
    chk("rst_uio", uio_out, 8'h00);

    // Generator from seed: bits 1..28 zero, 29..31 one
    rst_n = 1'b1;
    ui_in = 8'h01;
    tick_n(SYNC + 28);
    chk("gen28_byte", uo_out, 8'h00);
    chk("gen28_ser", {7'b0, uio_out[1]}, 8'h00);
    tick();
    chk("gen29_ser", {7'b0, uio_out[1]}, 8'h01);
    tick_n(2);
    chk("gen31_byte", uo_out, 8'h07);

    // gen_en toggling with random select: freeze and resume checked per cycle
    ui_in = 8'h00;
    tick_n(8);
    for (int i = 0; i < 200; i++) begin
      ui_in = {2'($urandom_range(0, 3)), 5'b0, 1'($urandom_range(0, 3) != 0)};
      tick();
    end

    // Loopback lock
    do_reset();
    rst_n = 1'b1;
    ui_in = 8'h53;
    wait_lock("lock_loopback", 100, lat);
    chk("lock_latency_ok", {7'b0, (lat > 0 && lat <= 70)}, 8'h01);
    for (int i = 0; i < 2000; i++) begin
      ui_in = {2'($urandom_range(0, 3)), 6'h13};
      tick();
    end
    ui_in = 8'h53;
    tick_n(3);
    chk("lock_run_err0", uo_out, 8'h00);
    chk("lock_run_locked", {7'b0, uio_out[2]}, 8'h01);

    // Single injection: three counted errors, lock held
    pulses = 0;
    for (int i = 0; i < 84; i++) begin
      ui_in = (i < 4) ? 8'h57 : 8'h53;
      tick();
      pulses += int'(uio_out[3]);
    end
    chk("inj_pulses", 8'(pulses), 8'd3);
    chk("inj_err_cnt", uo_out, 8'd3);
    chk("inj_lock", {7'b0, uio_out[2]}, 8'h01);

    // Second injection up to a count of 5, then clear with a fresh injection
    ui_in = 8'h57;
    tick_n(3);
    ui_in = 8'h53;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (uo_out === 8'd5) begin found = 1; break; end
    end
    chk("err_reach5", uo_out, 8'd5);
    ui_in = 8'h77;
    tick_n(4);
    chk("clr_lo", uo_out, 8'h00);
    ui_in = 8'hB7;
    tick_n(3);
    chk("clr_hi", uo_out, 8'h00);
    tick_n(40);
    ui_in = 8'h77;
    tick_n(3);
    chk("clr_lo_held", uo_out, 8'h00);
    ui_in = 8'h53;
    tick_n(40);

    // External rx held low: never locks; loopback then locks
    do_reset();
    rst_n = 1'b1;
    ui_in = 8'h03;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      seen = seen | uio_out[2];
    end
    chk("ext_zero_nolock", {7'b0, seen}, 8'h00);
    ui_in = 8'h43;
    tick_n(3);
    chk("ext_zero_err0", uo_out, 8'h00);
    ui_in = 8'h13;
    wait_lock("ext_to_loopback_lock", 100, lat);

    // Randomized mix of all controls and external rx
    for (int i = 0; i < 800; i++) begin
      ui_in = {2'($urandom_range(0, 3)),
               1'($urandom_range(0, 29) == 0),
               1'($urandom_range(0, 6) != 0),
               1'($urandom_range(0, 1)),
               1'($urandom_range(0, 4) == 0),
               1'($urandom_range(0, 9) != 0),
               1'($urandom_range(0, 9) != 0)};
      uio_in = 8'($urandom_range(0, 255));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tt_um_lampham_prbs31.md
Name: tt_um_lampham_prbs31

Overview:
- TinyTapeout user tile: a PRBS31 pattern generator (x^31 + x^28 + 1) paired with a self-synchronising PRBS31 checker.
- Has single-shot error injection, a lock indicator and a saturating error counter.
- Generator output is available serially on a bidirectional pin and as a byte on uo_out.
- Checker input is either internal loopback or an external serial pin.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers on ui_in and uio_in[0].
- ERR_W, 16, error counter width.
- LOCK_MATCHES, 32, consecutive matching bits required to assert lock.
- UNLOCK_ERRS, 3, consecutive mismatches that drop lock.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- ena  in  1  tile select; ignored functionally.
- ui_in  in  8  bit0 gen_en, bit1 chk_en, bit2 inject (rising edge), bit4 loopback (1 = internal), bit5 clr_err, bits7:6 uo_out select; bit3 reserved.
- uo_out  out  8  mux by sel: 00 gen byte, 01 err_cnt[7:0], 10 err_cnt[15:8], 11 {lock, 4'b0, err_sat, chk_en_s, gen_en_s}.
- uio_in  in  8  bit0 external serial rx; others unused.
- uio_out  out  8  bit0 0, bit1 serial PRBS, bit2 lock, bit3 err_pulse, bits7:4 err_cnt[3:0].
- uio_oe  out  8  constant 8'b1111_1110.

Interface rule: one clock; reset is synchronous and active-low.

Behaviour:
- Reset: active when rst_n is low at a clk edge.
  - Generator LFSR s[30:0] = 31'h7FFF_FFFF.
  - Checker register r = 0; match count = 0; error run = 0; lock = 0; err_cnt = 0; err_pulse = 0; serial out = 0; synchroniser flops = 0.
  - uo_out = 0x00 (sel synchroniser = 00, gen byte = s[7:0] masked to 0 during reset).
- Synchronisation: all ui_in bits and uio_in[0] pass through SYNC_STAGES flops before use. Suffix _s means synchronised.
- Generator: on each edge with gen_en_s = 1:
  - b = s[30] ^ s[27]; s <= {s[29:0], b}; serial out register <= b ^ inj_pending; inj_pending clears.
  - With gen_en_s = 0, the LFSR and serial output hold.
  - Gen byte = s[7:0], where bit0 is the newest bit.
  - From reset, bits 1..28 are 0 and bits 29..31 are 1.
- Injection: a rising edge of inject_s sets inj_pending, which flips exactly one subsequent emitted serial bit. The LFSR is not corrupted. Multiple edges before emission count once.
- Checker input: rx = loopback_s ? serial out register : synchronised uio_in[0].
- Checker step: each edge with chk_en_s = 1:
  - pred = r[30] ^ r[27]; mism = (pred != rx); r <= {r[29:0], rx}.
  - Comparison is valid only after 31 bits have been filled since reset or since chk_en rose; a fill counter is required.
- Lock:
  - While unlocked, each valid match increments the match count; a mismatch zeroes it.
  - Lock = 1 when the count reaches LOCK_MATCHES and r != 0 (the all-zero stream never locks).
  - While locked, UNLOCK_ERRS consecutive mismatches clear lock and the match count.
- Errors:
  - Each valid mismatch while locked pulses err_pulse (1 cycle) and increments err_cnt.
  - err_cnt saturates at all-ones; err_sat = 1 when saturated.
  - clr_err_s = 1 zeroes err_cnt synchronously and has priority over an increment in the same cycle.
- Self-sync property: one injected bit error yields exactly 3 counted errors (at the bit itself, at tap 28, at tap 31).
- chk_en_s = 0: the checker holds all state except the fill counter, which resets.

Decomposition:
- Package prbs31_pkg holds:
  - PRBS_LEN = 31, TAP_A = 30, TAP_B = 27, SEED = 31'h7FFF_FFFF;
  - uo_out select encodings;
  - status bit positions.
- Natural sub-module: prbs31_checker (fill/lock/error counter), instantiated once beside the inline generator and synchronisers.

Test Plan:
- Reset, gen_en = 1, sel = 00:
  - after 28 generator steps, uo_out = 0x00 and uio_out[1] = 0;
  - the 29th bit is 1;
  - after 31 steps, uo_out = 0x07.
- gen_en toggled 1→0 mid-stream → uo_out and uio_out[1] frozen while 0; the sequence resumes without skipped bits.
- Loopback = 1, chk_en = 1, gen_en = 1 → lock (uio_out[2]) asserts within 31 + 32 + sync cycles; err_cnt stays 0 for 2000 cycles.
- While locked, one inject rising edge → err_cnt = 3, three err_pulse cycles, lock stays 1.
- Loopback = 0, uio_in[0] held 0 → lock never asserts, err_cnt = 0; switching to loopback → lock asserts.
- err_cnt = 5, assert clr_err together with an injection → err_cnt reads 0 on sel = 01/10 while clr is held.
